// File: rtl/mpu_load_stream_pkg.sv
// Shared types and width helpers for the parametrised MPU matrix load path.
package mpu_load_stream_pkg;

    typedef enum logic [1:0] {
        LOAD_IDLE    = 2'd0,
        LOAD_REQUEST = 2'd1,
        LOAD_MATRIX  = 2'd2,
        LOAD_PAD     = 2'd3
    } load_state_e;

    // Width of a dimension field that must be able to hold 0..maxDim.
    function automatic int dimWidth(input int maxDim);
        return $clog2(maxDim + 1);
    endfunction

    // Width of an index 0..count-1, kept at least one bit wide.
    function automatic int idxWidth(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/mpu_rc_counter.sv
// Row-major row/column walker with runtime limits; last flags the final position.
module mpu_rc_counter
    import mpu_load_stream_pkg::*;
#(
    parameter int M = 3,
    parameter int N = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_inc,
    input  logic                   i_clr,
    input  logic [dimWidth(M)-1:0] i_rowLimit,
    input  logic [dimWidth(N)-1:0] i_colLimit,
    output logic [idxWidth(M)-1:0] o_row,
    output logic [idxWidth(N)-1:0] o_col,
    output logic                   o_last
);

    localparam int RLW = dimWidth(M);
    localparam int CLW = dimWidth(N);
    localparam int RW  = idxWidth(M);
    localparam int CW  = idxWidth(N);

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          w_colWrap;

    assign w_colWrap = (CLW'(r_col) == i_colLimit - CLW'(1));
    assign o_last    = w_colWrap && (RLW'(r_row) == i_rowLimit - RLW'(1));
    assign o_row     = r_row;
    assign o_col     = r_col;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_inc) begin
            if (w_colWrap) begin
                r_col <= '0;
                r_row <= r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mpu_load_stream.sv
// Matrix load path: validates a load request, streams row-major elements into
// the register-file write port, optionally zero-pads the rest, and can abort.
module mpu_load_stream
    import mpu_load_stream_pkg::*;
#(
    parameter int FP               = 32,
    parameter int M                = 3,
    parameter int N                = 3,
    parameter int MATRIX_REGISTERS = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  load_req_in,
    input  logic [dimWidth(M)-1:0]                m_in,
    input  logic [dimWidth(N)-1:0]                n_in,
    input  logic [idxWidth(MATRIX_REGISTERS)-1:0] dest_addr_in,
    input  logic                                  pad_en_in,
    input  logic                                  abort_in,
    output logic                                  load_ready_out,
    input  logic                                  element_valid_in,
    input  logic [FP-1:0]                         element_in,
    output logic                                  element_ready_out,
    output logic                                  reg_wr_en_out,
    output logic [idxWidth(MATRIX_REGISTERS)-1:0] reg_wr_addr_out,
    output logic [idxWidth(M)-1:0]                reg_wr_row_out,
    output logic [idxWidth(N)-1:0]                reg_wr_col_out,
    output logic [FP-1:0]                         reg_wr_data_out,
    output logic                                  done_out,
    output logic                                  error_out
);

    localparam int DW_M = dimWidth(M);
    localparam int DW_N = dimWidth(N);
    localparam int AW   = idxWidth(MATRIX_REGISTERS);
    localparam int RW   = idxWidth(M);
    localparam int CW   = idxWidth(N);

    load_state_e   r_state;
    logic [DW_M-1:0] r_m;
    logic [DW_N-1:0] r_n;
    logic [AW-1:0] r_dest;
    logic          r_padEn;
    logic          r_wrEn;
    logic [AW-1:0] r_wrAddr;
    logic [RW-1:0] r_wrRow;
    logic [CW-1:0] r_wrCol;
    logic [FP-1:0] r_wrData;
    logic          r_done;
    logic          r_error;

    logic [RW-1:0]   w_row;
    logic [CW-1:0]   w_col;
    logic            w_last;
    logic [DW_M-1:0] w_rowLimit;
    logic [DW_N-1:0] w_colLimit;
    logic            w_handshake;
    logic            w_padWrite;
    logic            w_needPad;
    logic            w_dimsOk;
    logic            w_cntInc;
    logic            w_cntClr;

    assign w_dimsOk    = (m_in != '0) && (m_in <= DW_M'(M)) && (n_in != '0) && (n_in <= DW_N'(N));
    assign w_handshake = element_valid_in && (r_state == LOAD_MATRIX);
    assign w_padWrite  = (r_state == LOAD_PAD) && ((DW_M'(w_row) >= r_m) || (DW_N'(w_col) >= r_n));
    assign w_needPad   = r_padEn && ((r_m < DW_M'(M)) || (r_n < DW_N'(N)));

    // One counter serves both phases: captured limits while loading, full size while padding.
    assign w_rowLimit = (r_state == LOAD_PAD) ? DW_M'(M) : r_m;
    assign w_colLimit = (r_state == LOAD_PAD) ? DW_N'(N) : r_n;
    assign w_cntInc   = w_handshake || (r_state == LOAD_PAD);
    assign w_cntClr   = (r_state == LOAD_IDLE) || (r_state == LOAD_REQUEST) || (w_handshake && w_last);

    mpu_rc_counter #(.M(M), .N(N)) u_rcCounter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inc      (w_cntInc),
        .i_clr      (w_cntClr),
        .i_rowLimit (w_rowLimit),
        .i_colLimit (w_colLimit),
        .o_row      (w_row),
        .o_col      (w_col),
        .o_last     (w_last)
    );

    // Write strobe, done and error are one-cycle pulses rebuilt every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= LOAD_IDLE;
            r_m      <= '0;
            r_n      <= '0;
            r_dest   <= '0;
            r_padEn  <= 1'b0;
            r_wrEn   <= 1'b0;
            r_wrAddr <= '0;
            r_wrRow  <= '0;
            r_wrCol  <= '0;
            r_wrData <= '0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_wrEn   <= 1'b0;
            r_wrAddr <= '0;
            r_wrRow  <= '0;
            r_wrCol  <= '0;
            r_wrData <= '0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            case (r_state)
                LOAD_IDLE: begin
                    if (load_req_in) begin
                        if (w_dimsOk) begin
                            r_m     <= m_in;
                            r_n     <= n_in;
                            r_dest  <= dest_addr_in;
                            r_padEn <= pad_en_in;
                            r_state <= LOAD_REQUEST;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                LOAD_REQUEST: begin
                    if (abort_in) begin
                        r_error <= 1'b1;
                        r_state <= LOAD_IDLE;
                    end else begin
                        r_state <= LOAD_MATRIX;
                    end
                end
                LOAD_MATRIX: begin
                    if (abort_in) begin
                        r_error <= 1'b1;
                        r_state <= LOAD_IDLE;
                    end else if (w_handshake) begin
                        r_wrEn   <= 1'b1;
                        r_wrAddr <= r_dest;
                        r_wrRow  <= w_row;
                        r_wrCol  <= w_col;
                        r_wrData <= element_in;
                        if (w_last) begin
                            if (w_needPad) begin
                                r_state <= LOAD_PAD;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= LOAD_IDLE;
                            end
                        end
                    end
                end
                LOAD_PAD: begin
                    if (abort_in) begin
                        r_error <= 1'b1;
                        r_state <= LOAD_IDLE;
                    end else begin
                        if (w_padWrite) begin
                            r_wrEn   <= 1'b1;
                            r_wrAddr <= r_dest;
                            r_wrRow  <= w_row;
                            r_wrCol  <= w_col;
                        end
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= LOAD_IDLE;
                        end
                    end
                end
                default: r_state <= LOAD_IDLE;
            endcase
        end
    end

    assign load_ready_out    = (r_state == LOAD_IDLE);
    assign element_ready_out = (r_state == LOAD_MATRIX);
    assign reg_wr_en_out     = r_wrEn;
    assign reg_wr_addr_out   = r_wrAddr;
    assign reg_wr_row_out    = r_wrRow;
    assign reg_wr_col_out    = r_wrCol;
    assign reg_wr_data_out   = r_wrData;
    assign done_out          = r_done;
    assign error_out         = r_error;

endmodule

// File: tb/tb_mpu_load_stream.sv
// Scoreboard bench for mpu_load_stream: expected writes are queued by the stimulus
// and popped by a monitor whenever the write strobe is seen.
module tb_mpu_load_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        loadReq = 1'b0;
    logic [1:0]  mIn = '0;
    logic [1:0]  nIn = '0;
    logic [2:0]  destAddr = '0;
    logic        padEn = 1'b0;
    logic        abortIn = 1'b0;
    logic        elementValid = 1'b0;
    logic [31:0] elementIn = '0;

    logic        load_ready_out;
    logic        element_ready_out;
    logic        reg_wr_en_out;
    logic [2:0]  reg_wr_addr_out;
    logic [1:0]  reg_wr_row_out;
    logic [1:0]  reg_wr_col_out;
    logic [31:0] reg_wr_data_out;
    logic        done_out;
    logic        error_out;

    mpu_load_stream #(.FP(32), .M(3), .N(3), .MATRIX_REGISTERS(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .load_req_in       (loadReq),
        .m_in              (mIn),
        .n_in              (nIn),
        .dest_addr_in      (destAddr),
        .pad_en_in         (padEn),
        .abort_in          (abortIn),
        .load_ready_out    (load_ready_out),
        .element_valid_in  (elementValid),
        .element_in        (elementIn),
        .element_ready_out (element_ready_out),
        .reg_wr_en_out     (reg_wr_en_out),
        .reg_wr_addr_out   (reg_wr_addr_out),
        .reg_wr_row_out    (reg_wr_row_out),
        .reg_wr_col_out    (reg_wr_col_out),
        .reg_wr_data_out   (reg_wr_data_out),
        .done_out          (done_out),
        .error_out         (error_out)
    );

    // A 2x2 instance where a dimension of 3 is representable yet above the maximum.
    logic        d2LoadReq = 1'b0;
    logic [1:0]  d2M = '0;
    logic [1:0]  d2N = '0;
    logic        d2LoadReady, d2ElemReady, d2WrEn, d2Done, d2Error;
    logic [2:0]  d2WrAddr;
    logic [0:0]  d2WrRow, d2WrCol;
    logic [31:0] d2WrData;

    mpu_load_stream #(.FP(32), .M(2), .N(2), .MATRIX_REGISTERS(8)) dut2 (
        .clk               (clk),
        .rst_n             (rst_n),
        .load_req_in       (d2LoadReq),
        .m_in              (d2M),
        .n_in              (d2N),
        .dest_addr_in      (3'd0),
        .pad_en_in         (1'b0),
        .abort_in          (1'b0),
        .load_ready_out    (d2LoadReady),
        .element_valid_in  (1'b0),
        .element_in        (32'd0),
        .element_ready_out (d2ElemReady),
        .reg_wr_en_out     (d2WrEn),
        .reg_wr_addr_out   (d2WrAddr),
        .reg_wr_row_out    (d2WrRow),
        .reg_wr_col_out    (d2WrCol),
        .reg_wr_data_out   (d2WrData),
        .done_out          (d2Done),
        .error_out         (d2Error)
    );

    typedef struct packed {
        logic [2:0]  addr;
        logic [1:0]  row;
        logic [1:0]  col;
        logic [31:0] data;
    } wr_t;

    wr_t         expQ[$];
    int          assertCount = 0;
    int          failCount = 0;
    int          doneCount = 0;
    int          errorCount = 0;
    int          cyc = 0;
    logic [31:0] fpVal [1:9];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pushWrite(input logic [2:0] a, input logic [1:0] r, input logic [1:0] c, input logic [31:0] d);
        wr_t e;
        e.addr = a; e.row = r; e.col = c; e.data = d;
        expQ.push_back(e);
    endtask

    // Monitor: every observed write strobe is matched against the head of the queue.
    always @(negedge clk) begin
        wr_t e;
        if (reg_wr_en_out) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWrite", reg_wr_en_out, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("wrAddr", reg_wr_addr_out, e.addr);
                checkOutput("wrRow", reg_wr_row_out, e.row);
                checkOutput("wrCol", reg_wr_col_out, e.col);
                checkOutput("wrData", reg_wr_data_out, e.data);
            end
        end
        if (done_out) doneCount++;
        if (error_out) errorCount++;
    end

    task automatic applyStimulus(input logic [1:0] m, input logic [1:0] n, input logic [2:0] dest,
                                 input logic pad, output int reqCyc);
        loadReq = 1'b1; mIn = m; nIn = n; destAddr = dest; padEn = pad;
        reqCyc = cyc;
        checkOutput("loadReadyAtReq", load_ready_out, 1);
        @(posedge clk); #1;
        loadReq = 1'b0;
    endtask

    task automatic sendElement(input logic [31:0] d);
        int waited = 0;
        elementValid = 1'b1; elementIn = d;
        while (!element_ready_out && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!element_ready_out) checkOutput("elementReadyTimeout", element_ready_out, 1);
        @(posedge clk); #1;
        elementValid = 1'b0;
    endtask

    task automatic waitForDone(input string name, input int expCycle);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_out && n < 40);
        checkOutput({name, "DoneSeen"}, done_out, 1);
        checkOutput({name, "DoneCycle"}, cyc, expCycle);
        checkOutput({name, "WrWithDone"}, reg_wr_en_out, 1);
        checkOutput({name, "ReadyWithDone"}, load_ready_out, 1);
        @(negedge clk);
        checkOutput({name, "QueueEmpty"}, expQ.size(), 0);
    endtask

    initial begin
        #100000;
        $display("[TB] watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        int k;
        int d0;
        int e0;
        fpVal = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                  32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rstLoadReady", load_ready_out, 1);
        checkOutput("rstElemReady", element_ready_out, 0);
        checkOutput("rstWrEn", reg_wr_en_out, 0);
        checkOutput("rstWrData", reg_wr_data_out, 0);
        checkOutput("rstDone", done_out, 0);
        checkOutput("rstError", error_out, 0);
        @(posedge clk); #1;

        // Full 3x3 load to register 5 with continuous valid
        $display("[TB] 3x3 continuous load");
        k = 1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                pushWrite(3'd5, 2'(r), 2'(c), fpVal[k]);
                k++;
            end
        applyStimulus(2'd3, 2'd3, 3'd5, 1'b0, t);
        for (int i = 1; i <= 9; i++) sendElement(fpVal[i]);
        waitForDone("full3x3", t + 11);

        // 2x2 load to register 1 with zero padding of the remaining positions
        $display("[TB] 2x2 padded load");
        pushWrite(3'd1, 2'd0, 2'd0, fpVal[1]);
        pushWrite(3'd1, 2'd0, 2'd1, fpVal[2]);
        pushWrite(3'd1, 2'd1, 2'd0, fpVal[3]);
        pushWrite(3'd1, 2'd1, 2'd1, fpVal[4]);
        pushWrite(3'd1, 2'd0, 2'd2, 32'd0);
        pushWrite(3'd1, 2'd1, 2'd2, 32'd0);
        pushWrite(3'd1, 2'd2, 2'd0, 32'd0);
        pushWrite(3'd1, 2'd2, 2'd1, 32'd0);
        pushWrite(3'd1, 2'd2, 2'd2, 32'd0);
        applyStimulus(2'd2, 2'd2, 3'd1, 1'b1, t);
        for (int i = 1; i <= 4; i++) sendElement(fpVal[i]);
        waitForDone("pad2x2", t + 15);

        // Rejected requests: zero rows, zero columns, and above-maximum on the 2x2 instance
        $display("[TB] rejected requests");
        applyStimulus(2'd0, 2'd3, 3'd0, 1'b0, t);
        @(negedge clk);
        checkOutput("errM0Pulse", error_out, 1);
        checkOutput("errM0Ready", load_ready_out, 1);
        checkOutput("errM0NoWrite", reg_wr_en_out, 0);
        @(negedge clk);
        checkOutput("errM0PulseEnds", error_out, 0);
        checkOutput("errM0StillIdle", load_ready_out, 1);
        @(posedge clk); #1;
        applyStimulus(2'd2, 2'd0, 3'd0, 1'b0, t);
        @(negedge clk);
        checkOutput("errN0Pulse", error_out, 1);
        checkOutput("errN0Ready", load_ready_out, 1);
        @(negedge clk);
        checkOutput("errN0StillIdle", load_ready_out, 1);
        @(posedge clk); #1;
        d2LoadReq = 1'b1; d2M = 2'd3; d2N = 2'd1;
        @(posedge clk); #1;
        d2LoadReq = 1'b0;
        @(negedge clk);
        checkOutput("d2ErrMOver", d2Error, 1);
        checkOutput("d2ReadyMOver", d2LoadReady, 1);
        checkOutput("d2NoWriteMOver", d2WrEn, 0);
        @(posedge clk); #1;
        d2LoadReq = 1'b1; d2M = 2'd1; d2N = 2'd3;
        @(posedge clk); #1;
        d2LoadReq = 1'b0;
        @(negedge clk);
        checkOutput("d2ErrNOver", d2Error, 1);
        checkOutput("d2ReadyNOver", d2LoadReady, 1);
        @(negedge clk);
        checkOutput("d2StillIdle", d2LoadReady, 1);
        @(posedge clk); #1;

        // 3x3 load with a one-cycle valid gap between elements
        $display("[TB] 3x3 load with valid gaps");
        k = 1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                pushWrite(3'd3, 2'(r), 2'(c), fpVal[k]);
                k++;
            end
        applyStimulus(2'd3, 2'd3, 3'd3, 1'b0, t);
        for (int i = 1; i <= 9; i++) begin
            sendElement(fpVal[i]);
            if (i < 9) begin
                @(posedge clk); #1;
            end
        end
        waitForDone("gapped3x3", t + 19);

        // Abort together with the fifth handshake
        $display("[TB] abort mid-transfer");
        d0 = doneCount;
        e0 = errorCount;
        for (int i = 0; i < 4; i++) pushWrite(3'd2, 2'(i / 3), 2'(i % 3), fpVal[i + 1]);
        applyStimulus(2'd3, 2'd3, 3'd2, 1'b0, t);
        for (int i = 1; i <= 4; i++) sendElement(fpVal[i]);
        checkOutput("readyBeforeAbort", element_ready_out, 1);
        elementValid = 1'b1; elementIn = fpVal[5]; abortIn = 1'b1;
        @(posedge clk); #1;
        elementValid = 1'b0; abortIn = 1'b0;
        @(negedge clk);
        checkOutput("abortError", error_out, 1);
        checkOutput("abortIdle", load_ready_out, 1);
        checkOutput("abortNoWrite", reg_wr_en_out, 0);
        checkOutput("abortElemReady", element_ready_out, 0);
        repeat (3) @(negedge clk);
        checkOutput("abortQueueEmpty", expQ.size(), 0);
        checkOutput("abortNoDone", doneCount, d0);
        checkOutput("abortOneError", errorCount, e0 + 1);
        @(posedge clk); #1;

        // Reset after the fifth write of a 3x3 load, then a fresh 1x1 load
        $display("[TB] reset mid-transfer");
        d0 = doneCount;
        e0 = errorCount;
        for (int i = 0; i < 5; i++) pushWrite(3'd6, 2'(i / 3), 2'(i % 3), fpVal[i + 1]);
        applyStimulus(2'd3, 2'd3, 3'd6, 1'b0, t);
        for (int i = 1; i <= 5; i++) sendElement(fpVal[i]);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midRstLoadReady", load_ready_out, 1);
        checkOutput("midRstElemReady", element_ready_out, 0);
        checkOutput("midRstWrEn", reg_wr_en_out, 0);
        checkOutput("midRstWrAddr", reg_wr_addr_out, 0);
        checkOutput("midRstWrData", reg_wr_data_out, 0);
        checkOutput("midRstDone", done_out, 0);
        checkOutput("midRstError", error_out, 0);
        checkOutput("midRstQueueEmpty", expQ.size(), 0);
        @(posedge clk); #1;
        pushWrite(3'd7, 2'd0, 2'd0, fpVal[9]);
        applyStimulus(2'd1, 2'd1, 3'd7, 1'b0, t);
        sendElement(fpVal[9]);
        waitForDone("after1x1", t + 3);
        checkOutput("rstNoSpuriousError", errorCount, e0);
        checkOutput("rstOnlyOneDone", doneCount, d0 + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
